// File: rtl/lzw_code_packer.sv
// lzw_code_packer: packs fixed-width LZW codes LSB-first into a byte stream.
// Bytes leave on a ready/valid handshake. End-of-stream zero-pads and
// flushes the final partial byte, then raises a one-cycle completion pulse.
module lzw_code_packer #(
  parameter int CODE_W = 12
) (
  input  logic              CLK66,
  input  logic              RST_N,
  input  logic [CODE_W-1:0] CODE_IN,
  input  logic              CODE_VLD,
  output logic              CODE_RDY,
  input  logic              FLUSH,
  output logic [7:0]        BYTE_OUT,
  output logic              BYTE_VLD,
  input  logic              BYTE_RDY,
  output logic              PACK_DONE,
  output logic [15:0]       BYTE_CNT
);

  localparam int         ACC_W   = CODE_W + 7;
  localparam logic [4:0] CODE_W5 = 5'(CODE_W);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_FLSH = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [ACC_W-1:0] r_acc;
  logic [4:0]       r_cnt;
  logic             r_fp;
  logic [15:0]      r_byte_cnt;

  logic             w_accept;
  logic             w_emit;
  logic             w_fp_eff;
  logic             w_enter_flsh;
  logic [ACC_W-1:0] w_code_ext;

  // Zero-extend the code to accumulator width before it is shifted into place.
  assign w_code_ext = {{7{1'b0}}, CODE_IN};

  // A flush request counts as pending in the very cycle FLUSH arrives so an
  // empty or partial stream can start draining immediately.
  assign w_fp_eff     = r_fp || FLUSH;
  assign w_accept     = CODE_VLD && CODE_RDY;
  assign w_emit       = BYTE_VLD && BYTE_RDY;
  assign w_enter_flsh = (r_state == S_RUN) && (w_next_state == S_FLSH);

  assign BYTE_OUT = r_acc[7:0];
  assign BYTE_CNT = r_byte_cnt;

  // State register.
  always_ff @(posedge CLK66 or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: leave RUN once every full byte is out and a flush is pending.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_RUN: begin
        if (w_fp_eff && (r_cnt < 5'd8)) begin
          w_next_state = S_FLSH;
        end else begin
          w_next_state = S_RUN;
        end
      end
      S_FLSH: begin
        if (r_cnt == 5'd0) begin
          w_next_state = S_DONE;
        end else begin
          w_next_state = S_FLSH;
        end
      end
      S_DONE: begin
        w_next_state = S_RUN;
      end
      default: begin
        w_next_state = S_RUN;
      end
    endcase
  end

  // Output decode from registered state only; no input reaches an output.
  always_comb begin
    CODE_RDY  = 1'b0;
    BYTE_VLD  = 1'b0;
    PACK_DONE = 1'b0;
    case (r_state)
      S_RUN: begin
        CODE_RDY = (r_cnt < 5'd8) && !r_fp;
        BYTE_VLD = (r_cnt >= 5'd8);
      end
      S_FLSH: begin
        BYTE_VLD = (r_cnt != 5'd0);
      end
      S_DONE: begin
        PACK_DONE = 1'b1;
      end
      default: begin
        CODE_RDY  = 1'b0;
        BYTE_VLD  = 1'b0;
        PACK_DONE = 1'b0;
      end
    endcase
  end

  // Flush-pending flag: set by FLUSH while running, cleared on entry to flush.
  always_ff @(posedge CLK66 or negedge RST_N) begin
    if (!RST_N) begin
      r_fp <= 1'b0;
    end else if (w_enter_flsh) begin
      r_fp <= 1'b0;
    end else if (FLUSH && (r_state == S_RUN)) begin
      r_fp <= 1'b1;
    end else begin
      r_fp <= r_fp;
    end
  end

  // Accumulator, bit count and byte counter. Accept needs CNT<8 and RUN-mode
  // emit needs CNT>=8, so the two branches never compete for the same cycle.
  always_ff @(posedge CLK66 or negedge RST_N) begin
    if (!RST_N) begin
      r_acc      <= '0;
      r_cnt      <= 5'd0;
      r_byte_cnt <= 16'd0;
    end else if (r_state == S_DONE) begin
      r_acc      <= '0;
      r_cnt      <= 5'd0;
      r_byte_cnt <= 16'd0;
    end else if (w_accept) begin
      r_acc      <= r_acc | (w_code_ext << r_cnt);
      r_cnt      <= r_cnt + CODE_W5;
      r_byte_cnt <= r_byte_cnt;
    end else if (w_emit) begin
      r_acc      <= r_acc >> 8;
      r_cnt      <= (r_cnt >= 5'd8) ? (r_cnt - 5'd8) : 5'd0;
      r_byte_cnt <= r_byte_cnt + 16'd1;
    end else begin
      r_acc      <= r_acc;
      r_cnt      <= r_cnt;
      r_byte_cnt <= r_byte_cnt;
    end
  end

endmodule

// File: tb/tb_lzw_code_packer.sv
// Testbench for lzw_code_packer (CODE_W=12): directed scenarios plus a random
// stream checked against a bit-level reference model.
module tb_lzw_code_packer;

  logic        CLK66;
  logic        RST_N;
  logic [11:0] CODE_IN;
  logic        CODE_VLD;
  logic        CODE_RDY;
  logic        FLUSH;
  logic [7:0]  BYTE_OUT;
  logic        BYTE_VLD;
  logic        BYTE_RDY;
  logic        PACK_DONE;
  logic [15:0] BYTE_CNT;

  int checks;
  int failures;
  bit rand_rdy;

  logic [7:0]  cap_q[$];
  logic [11:0] sent_q[$];
  logic [7:0]  exp_q[$];

  lzw_code_packer #(.CODE_W(12)) dut (
    .CLK66(CLK66), .RST_N(RST_N), .CODE_IN(CODE_IN), .CODE_VLD(CODE_VLD),
    .CODE_RDY(CODE_RDY), .FLUSH(FLUSH), .BYTE_OUT(BYTE_OUT), .BYTE_VLD(BYTE_VLD),
    .BYTE_RDY(BYTE_RDY), .PACK_DONE(PACK_DONE), .BYTE_CNT(BYTE_CNT)
  );

  initial CLK66 = 1'b0;
  always #5 CLK66 = ~CLK66;

  // Byte monitor: a handshake seen at the falling edge completes on the next rising edge.
  always @(negedge CLK66) begin
    if (RST_N === 1'b1 && BYTE_VLD === 1'b1 && BYTE_RDY === 1'b1)
      cap_q.push_back(BYTE_OUT);
  end

  // Reference: concatenate code bits LSB-first, optionally zero-pad, cut into bytes.
  task automatic build_expected(input bit flush);
    bit bits[$];
    logic [7:0] v;
    exp_q.delete();
    foreach (sent_q[i])
      for (int k = 0; k < 12; k++) bits.push_back(sent_q[i][k]);
    if (flush)
      while ((bits.size() % 8) != 0) bits.push_back(1'b0);
    for (int i = 0; i + 8 <= bits.size(); i += 8) begin
      for (int k = 0; k < 8; k++) v[k] = bits[i+k];
      exp_q.push_back(v);
    end
  endtask

  task automatic do_reset();
    RST_N = 1'b0; CODE_VLD = 1'b0; FLUSH = 1'b0; CODE_IN = 12'h000;
    BYTE_RDY = 1'b1; rand_rdy = 1'b0;
    sent_q.delete();
    repeat (5) @(posedge CLK66);
    #1 RST_N = 1'b1;
  endtask

  // Offer one code until accepted; returns just after the accepting edge.
  task automatic send_code(input logic [11:0] c, output bit ok);
    CODE_IN = c; CODE_VLD = 1'b1; ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (rand_rdy) BYTE_RDY = 1'($urandom_range(0, 1));
      @(negedge CLK66);
      if (CODE_RDY === 1'b1) ok = 1'b1;
      @(posedge CLK66); #1;
      if (ok) break;
    end
    CODE_VLD = 1'b0;
    if (ok) sent_q.push_back(c);
  endtask

  task automatic pulse_flush();
    FLUSH = 1'b1;
    if (rand_rdy) BYTE_RDY = 1'($urandom_range(0, 1));
    @(posedge CLK66); #1;
    FLUSH = 1'b0;
  endtask

  // Wait for PACK_DONE; n = falling edges seen, bc = BYTE_CNT during the pulse.
  task automatic wait_done(input int budget, output int n, output bit ok, output logic [15:0] bc);
    n = 0; ok = 1'b0; bc = 16'hxxxx;
    for (int i = 0; i < budget; i++) begin
      if (rand_rdy) BYTE_RDY = 1'($urandom_range(0, 1));
      @(negedge CLK66);
      n++;
      if (PACK_DONE === 1'b1) begin ok = 1'b1; bc = BYTE_CNT; end
      @(posedge CLK66); #1;
      if (ok) break;
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0; CODE_VLD = 1'b0; FLUSH = 1'b0; CODE_IN = 12'h000; BYTE_RDY = 1'b1;
    repeat (5) @(posedge CLK66);
    #1 RST_N = 1'b1;
    @(negedge CLK66);
    checks++; if (BYTE_VLD !== 1'b0) begin failures++; $display("FAIL reset_byte_vld got=%0b exp=0", BYTE_VLD); end
    checks++; if (CODE_RDY !== 1'b1) begin failures++; $display("FAIL reset_code_rdy got=%0b exp=1", CODE_RDY); end
    checks++; if (PACK_DONE !== 1'b0) begin failures++; $display("FAIL reset_pack_done got=%0b exp=0", PACK_DONE); end
    checks++; if (BYTE_CNT !== 16'd0) begin failures++; $display("FAIL reset_byte_cnt got=%0d exp=0", BYTE_CNT); end
    checks++; if (BYTE_OUT !== 8'h00) begin failures++; $display("FAIL reset_byte_out got=%h exp=00", BYTE_OUT); end
    @(posedge CLK66); #1;
  endtask

  task automatic test_packing();
    int base;
    bit ok;
    logic [7:0] k[3];
    k[0] = 8'h23; k[1] = 8'h61; k[2] = 8'h45;
    do_reset();
    base = cap_q.size();
    send_code(12'h123, ok);
    @(negedge CLK66);
    checks++; if (BYTE_VLD !== 1'b1 || BYTE_OUT !== 8'h23) begin failures++; $display("FAIL pack_latency vld=%0b out=%h exp vld=1 out=23", BYTE_VLD, BYTE_OUT); end
    @(posedge CLK66); #1;
    send_code(12'h456, ok);
    checks++; if (!ok) begin failures++; $display("FAIL pack_accept got=timeout exp=accepted"); end
    repeat (4) @(posedge CLK66);
    #1;
    @(negedge CLK66);
    checks++; if (BYTE_CNT !== 16'd3) begin failures++; $display("FAIL pack_byte_cnt got=%0d exp=3", BYTE_CNT); end
    build_expected(1'b0);
    checks++; if (cap_q.size() - base != 3) begin failures++; $display("FAIL pack_nbytes got=%0d exp=3", cap_q.size() - base); end
    for (int i = 0; i < 3 && base + i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[base+i] !== k[i] || cap_q[base+i] !== exp_q[i]) begin
        failures++; $display("FAIL pack_byte%0d got=%h exp=%h", i, cap_q[base+i], k[i]);
      end
    end
    @(posedge CLK66); #1;
  endtask

  task automatic test_flush_empty();
    int base, n;
    bit ok;
    logic [15:0] bc;
    do_reset();
    base = cap_q.size();
    pulse_flush();
    wait_done(20, n, ok, bc);
    checks++; if (!ok || n != 2) begin failures++; $display("FAIL flush_empty_latency got=%0d ok=%0b exp=2", n, ok); end
    checks++; if (cap_q.size() != base) begin failures++; $display("FAIL flush_empty_nbytes got=%0d exp=0", cap_q.size() - base); end
  endtask

  task automatic test_flush_partial();
    int base, n;
    bit ok;
    logic [15:0] bc;
    do_reset();
    base = cap_q.size();
    send_code(12'hABC, ok);
    repeat (2) @(posedge CLK66);
    #1;
    pulse_flush();
    wait_done(20, n, ok, bc);
    checks++; if (!ok || n != 3) begin failures++; $display("FAIL flush_partial_latency got=%0d ok=%0b exp=3", n, ok); end
    checks++; if (bc !== 16'd2) begin failures++; $display("FAIL flush_cnt_before got=%0d exp=2", bc); end
    @(negedge CLK66);
    checks++; if (BYTE_CNT !== 16'd0) begin failures++; $display("FAIL flush_cnt_after got=%0d exp=0", BYTE_CNT); end
    checks++; if (PACK_DONE !== 1'b0) begin failures++; $display("FAIL flush_done_once got=%0b exp=0", PACK_DONE); end
    @(posedge CLK66); #1;
    build_expected(1'b1);
    checks++; if (cap_q.size() - base != 2) begin failures++; $display("FAIL flush_nbytes got=%0d exp=2", cap_q.size() - base); end
    for (int i = 0; i < exp_q.size() && base + i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[base+i] !== exp_q[i]) begin failures++; $display("FAIL flush_byte%0d got=%h exp=%h", i, cap_q[base+i], exp_q[i]); end
    end
  endtask

  task automatic test_backpressure();
    int base, n, bad;
    bit ok;
    logic [15:0] bc;
    do_reset();
    base = cap_q.size();
    BYTE_RDY = 1'b0;
    send_code(12'h123, ok);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK66);
      if (BYTE_VLD !== 1'b1 || BYTE_OUT !== 8'h23 || CODE_RDY !== 1'b0) bad++;
      @(posedge CLK66); #1;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL bp_hold got=%0d_bad_cycles exp=0 (vld=%0b out=%h rdy=%0b)", bad, BYTE_VLD, BYTE_OUT, CODE_RDY); end
    BYTE_RDY = 1'b1;
    pulse_flush();
    wait_done(30, n, ok, bc);
    checks++; if (!ok || bc !== 16'd2) begin failures++; $display("FAIL bp_done ok=%0b cnt=%0d exp ok=1 cnt=2", ok, bc); end
    build_expected(1'b1);
    checks++; if (cap_q.size() - base != exp_q.size()) begin failures++; $display("FAIL bp_nbytes got=%0d exp=%0d", cap_q.size() - base, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && base + i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[base+i] !== exp_q[i]) begin failures++; $display("FAIL bp_byte%0d got=%h exp=%h", i, cap_q[base+i], exp_q[i]); end
    end
  endtask

  task automatic test_simultaneous();
    int base, rdy_bad;
    bit ok, seen, done;
    do_reset();
    base = cap_q.size();
    send_code(12'h123, ok);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK66);
      if (CODE_RDY === 1'b1) begin seen = 1'b1; break; end
    end
    CODE_IN = 12'h7FF; CODE_VLD = 1'b1; FLUSH = 1'b1;
    @(posedge CLK66); #1;
    CODE_VLD = 1'b0; FLUSH = 1'b0;
    checks++; if (!seen) begin failures++; $display("FAIL sim_rdy got=0 exp=1"); end
    sent_q.push_back(12'h7FF);
    rdy_bad = 0; done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK66);
      if (PACK_DONE === 1'b1) begin done = 1'b1; break; end
      if (CODE_RDY !== 1'b0) rdy_bad++;
      @(posedge CLK66); #1;
    end
    @(posedge CLK66); #1;
    checks++; if (!done) begin failures++; $display("FAIL sim_done got=timeout exp=pulse"); end
    checks++; if (rdy_bad != 0) begin failures++; $display("FAIL sim_no_rdy got=%0d exp=0", rdy_bad); end
    @(negedge CLK66);
    checks++; if (CODE_RDY !== 1'b1) begin failures++; $display("FAIL sim_rdy_after got=%0b exp=1", CODE_RDY); end
    @(posedge CLK66); #1;
    build_expected(1'b1);
    checks++; if (cap_q.size() - base != 3) begin failures++; $display("FAIL sim_nbytes got=%0d exp=3", cap_q.size() - base); end
    for (int i = 0; i < exp_q.size() && base + i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[base+i] !== exp_q[i]) begin failures++; $display("FAIL sim_byte%0d got=%h exp=%h", i, cap_q[base+i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_midstream();
    int base;
    bit ok;
    do_reset();
    base = cap_q.size();
    BYTE_RDY = 1'b0;
    send_code(12'h5A5, ok);
    #2 RST_N = 1'b0;
    #1;
    checks++; if (BYTE_VLD !== 1'b0 || BYTE_OUT !== 8'h00 || CODE_RDY !== 1'b1) begin
      failures++; $display("FAIL midrst_async vld=%0b out=%h rdy=%0b exp 0/00/1", BYTE_VLD, BYTE_OUT, CODE_RDY);
    end
    repeat (3) @(posedge CLK66);
    #1 RST_N = 1'b1;
    BYTE_RDY = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK66);
      if (PACK_DONE === 1'b1) ok = 1'b1;
      @(posedge CLK66); #1;
    end
    checks++; if (ok || cap_q.size() != base) begin failures++; $display("FAIL midrst_discard done=%0b nbytes=%0d exp 0/0", ok, cap_q.size() - base); end
  endtask

  task automatic test_random();
    int base, n, tmo;
    bit ok;
    logic [15:0] bc;
    bit bits[$];
    logic [11:0] code;
    do_reset();
    base = cap_q.size();
    rand_rdy = 1'b1;
    tmo = 0;
    for (int i = 0; i < 1000; i++) begin
      send_code(12'($urandom_range(0, 4095)), ok);
      if (!ok) tmo++;
    end
    checks++; if (tmo != 0) begin failures++; $display("FAIL rand_accept got=%0d_timeouts exp=0", tmo); end
    pulse_flush();
    wait_done(5000, n, ok, bc);
    rand_rdy = 1'b0; BYTE_RDY = 1'b1;
    checks++; if (!ok || bc !== 16'd1500) begin failures++; $display("FAIL rand_done ok=%0b cnt=%0d exp ok=1 cnt=1500", ok, bc); end
    checks++; if (cap_q.size() - base != 1500) begin failures++; $display("FAIL rand_nbytes got=%0d exp=1500", cap_q.size() - base); end
    build_expected(1'b1);
    for (int i = 0; i < exp_q.size() && base + i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[base+i] !== exp_q[i]) begin failures++; $display("FAIL rand_byte%0d got=%h exp=%h", i, cap_q[base+i], exp_q[i]); end
    end
    for (int i = base; i < cap_q.size(); i++)
      for (int k = 0; k < 8; k++) bits.push_back(cap_q[i][k]);
    for (int i = 0; i < sent_q.size() && (i * 12 + 12) <= bits.size(); i++) begin
      for (int k = 0; k < 12; k++) code[k] = bits[i*12+k];
      checks++;
      if (code !== sent_q[i]) begin failures++; $display("FAIL rand_code%0d got=%h exp=%h", i, code, sent_q[i]); end
    end
  endtask

  initial begin
    checks = 0; failures = 0; rand_rdy = 1'b0;
    RST_N = 1'b0; CODE_VLD = 1'b0; FLUSH = 1'b0; CODE_IN = 12'h000; BYTE_RDY = 1'b1;
    test_reset();
    test_packing();
    test_flush_empty();
    test_flush_partial();
    test_backpressure();
    test_simultaneous();
    test_reset_midstream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lzw_code_packer.md
# lzw_code_packer

Bit-packing stage between the LZW compression core and the serial transmitter. It accepts fixed-width LZW output codes and packs them LSB-first into a contiguous bit stream. It emits that stream as bytes over a ready/valid handshake to the UART transmit path. On end-of-stream it zero-pads and flushes the final partial byte, then pulses a completion strobe that feeds the top-level final-done logic.

## Interface
- CODE_W, 12, LZW code width in bits; legal range 9..16.
- CLK66  input  1  system clock; all state updates on rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- CODE_IN  input  CODE_W  LZW code from compression core.
- CODE_VLD  input  1  CODE_IN valid.
- CODE_RDY  output  1  packer can accept a code this cycle.
- FLUSH  input  1  single-cycle end-of-stream pulse from the LZW core (its done indication).
- BYTE_OUT  output  8  packed byte to the serial transmitter.
- BYTE_VLD  output  1  BYTE_OUT valid.
- BYTE_RDY  input  1  transmitter accepts BYTE_OUT this cycle.
- PACK_DONE  output  1  one-cycle pulse: last byte of the stream has been accepted.
- BYTE_CNT  output  16  bytes emitted since reset or since the last PACK_DONE; wraps at 0xFFFF→0x0000.

## Operation
- State: accumulator ACC (CODE_W+7 bits), bit count CNT (5 bits, 0..CODE_W+7), flush-pending flag FP, and FSM {RUN, FLSH, DONE}.
- Code accept:
  - Fires when CODE_VLD && CODE_RDY.
  - CODE_RDY = (state==RUN) && (CNT<8) && !FP.
  - On accept: ACC |= CODE_IN << CNT; CNT += CODE_W.
- Byte emit:
  - BYTE_OUT = ACC[7:0].
  - BYTE_VLD = (CNT>=8) || (state==FLSH && CNT>0).
  - On BYTE_VLD && BYTE_RDY: ACC >>= 8 (zero-fill); CNT = (CNT>=8) ? CNT-8 : 0; BYTE_CNT += 1.
  - A partial byte (CNT<8) is emitted only in FLSH; the unused high bits are 0 because of zero-fill.
- Accept and emit are mutually exclusive by construction: accept requires CNT<8; emit in RUN requires CNT>=8.
- Flush:
  - FLUSH sets FP.
  - A code accepted in the same cycle FLUSH is asserted is kept (it is the last code).
  - RUN→FLSH when FP && CNT<8 (all full bytes drained); clear FP on entry.
  - FLSH→DONE when CNT==0, whether it got there by emit or by entering with CNT==0.
  - DONE lasts one cycle: PACK_DONE=1, ACC=0, CNT=0, BYTE_CNT=0, then →RUN.
- FLUSH while in FLSH or DONE is ignored; it does not set FP.
- Arithmetic:
  - CODE_IN is zero-extended before shifting.
  - Maximum CNT is 7+CODE_W (≤23), which fits in 5 bits; ACC never overflows.

## Timing
- Reset (RST_N low, asynchronous):
  - ACC=0, CNT=0, FP=0, state=RUN, BYTE_CNT=0, PACK_DONE=0.
  - Outputs: BYTE_VLD=0, BYTE_OUT=0x00, CODE_RDY=1.
- CODE_RDY, BYTE_VLD and BYTE_OUT are combinational from registers only. There is no input-to-output combinational path.
- Latency from a code accept to its first byte valid: 1 cycle.
- Latency from FLUSH to PACK_DONE, with BYTE_RDY held high:
  - CNT=0 at FLUSH: 2 cycles (FLSH, then DONE).
  - 0<CNT<8 at FLUSH: 3 cycles (FLSH, emit, DONE).
- Sustained throughput with BYTE_RDY=1: one byte per cycle while CNT>=8; one code per 2–3 cycles at CODE_W=12.
- BYTE_VLD, once asserted, stays asserted and BYTE_OUT stays stable until BYTE_RDY, unless RST_N is asserted.
- Reset mid-stream discards all buffered bits. No PACK_DONE is produced.

## Test plan
- Reset: hold RST_N low for 5 cycles, then release → BYTE_VLD=0, CODE_RDY=1, PACK_DONE=0, BYTE_CNT=0.
- Packing, CODE_W=12, BYTE_RDY=1: send codes 0x123 then 0x456 → bytes 0x23, 0x61, 0x45; BYTE_CNT=3.
- Flush with partial byte: send code 0xABC, then pulse FLUSH → bytes 0xBC, 0x0A; then PACK_DONE pulses once; BYTE_CNT reads 2 before the pulse and 0 after.
- Backpressure: hold BYTE_RDY=0 for 10 cycles after code 0x123 → BYTE_OUT stays at 0x23 with BYTE_VLD=1; CODE_RDY=0 (CNT=12); no byte is lost after release.
- Simultaneous events: assert FLUSH in the same cycle a code 0x7FF is accepted at CNT=4 → that code is packed; all bytes drain; PACK_DONE follows; no further CODE_RDY until PACK_DONE.
- Random stream: 1000 random 12-bit codes, random BYTE_RDY, then FLUSH. A scoreboard unpacks the bytes LSB-first and matches every code. Byte count must equal ceil(12000/8)=1500.
